// File: rtl/pe_feeder.sv
// pe_feeder: streams DEPTH-long operand vectors from the operand RAM into one
// edge of the PE systolic array, one byte per lane per cycle, with lane i
// delayed by i cycles so operands meet on the wavefront inside the array.
// Optional feature macro: PE_FEEDER_SKEW_EN (defined = per-lane skew stages,
// undefined = all lanes present their bytes in the same cycle).
module pe_feeder #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pe_en,
  output logic                rd_en,
  output logic [AW-1:0]       rd_addr,
  input  logic [LANES*DW-1:0] rd_data,
  output logic [LANES-1:0]    out_vld,
  output logic [LANES*DW-1:0] out_data
);

`ifdef PE_FEEDER_SKEW_EN
  localparam int unsigned SKEW = 1;
`else
  localparam int unsigned SKEW = 0;
`endif

  // Cycles spent in DRAIN after the last read until the final byte leaves the
  // last lane (the read-return stage plus the deepest skew chain).
  localparam int unsigned DRAIN_LEN = (SKEW != 0) ? LANES : 1;
  localparam int unsigned CW        = $clog2(DEPTH + LANES + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic          busy_d;
  logic          done_d;
  logic          rd_en_d;
  logic [AW-1:0] rd_addr_d;
  logic          rd_pend;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; DRAIN hands back to IDLE on the done edge so a new start
  // can be sampled the very next cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = FETCH;
      FETCH:   if (cnt == CW'(DEPTH - 1)) next_state = DRAIN;
      DRAIN:   if (cnt == CW'(DRAIN_LEN)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output/counter next values; cnt is the read index in FETCH and the drain
  // cycle count in DRAIN.
  always_comb begin
    cnt_d     = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr;
    case (state)
      IDLE: begin
        busy_d = start;
      end
      FETCH: begin
        busy_d    = 1'b1;
        rd_en_d   = 1'b1;
        rd_addr_d = AW'(cnt);
        cnt_d     = (cnt == CW'(DEPTH - 1)) ? '0 : cnt + CW'(1);
      end
      DRAIN: begin
        busy_d = 1'b1;
        done_d = (cnt == CW'(DRAIN_LEN));
        cnt_d  = cnt + CW'(1);
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Control output and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      cnt     <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      rd_en   <= rd_en_d;
      rd_addr <= rd_addr_d;
    end
  end

  assign pe_en = busy;

  // Marks the cycle in which rd_data carries the word requested by rd_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rd_en;
    end
  end

  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    // Stage 0 is the read-return register; stages 1..i form the skew chain.
    localparam int unsigned NST = i * SKEW + 1;

    logic          vld_q [NST];
    logic [DW-1:0] dat_q [NST];

    // Read-return stage: capture this lane's byte, hold it when idle
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q[0] <= 1'b0;
        dat_q[0] <= '0;
      end else begin
        vld_q[0] <= rd_pend;
        if (rd_pend) dat_q[0] <= rd_data[i*DW +: DW];
      end
    end

    for (genvar j = 1; j < int'(NST); j++) begin : g_stage
      // Skew stage: data only advances with a valid so the tail holds its value
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q[j] <= 1'b0;
          dat_q[j] <= '0;
        end else begin
          vld_q[j] <= vld_q[j-1];
          if (vld_q[j-1]) dat_q[j] <= dat_q[j-1];
        end
      end
    end

    assign out_vld[i]          = vld_q[NST-1];
    assign out_data[i*DW +: DW] = dat_q[NST-1];
  end

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: directed and randomized checks of pe_feeder against a
// cycle-indexed timing model (outputs derived from edges since the accepted start).
module tb_pe_feeder;

  localparam int unsigned LANES = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = $clog2(DEPTH);

`ifdef PE_FEEDER_SKEW_EN
  localparam int SK = 1;
`else
  localparam int SK = 0;
`endif

  // Edge index (relative to the start edge) of the done cycle.
  localparam int LAT = int'(DEPTH) + (SK != 0 ? int'(LANES) : 1) + 1;

  logic                clk;
  logic                rst;
  logic                start;
  logic                busy;
  logic                done;
  logic                pe_en;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic [LANES*DW-1:0] rd_data = '0;
  logic [LANES-1:0]    out_vld;
  logic [LANES*DW-1:0] out_data;

  logic [LANES*DW-1:0] mem [DEPTH];

  pe_feeder #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pe_en    (pe_en),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_vld  (out_vld),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand RAM with one cycle read latency
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  int            vectors;
  int            miscompares;
  int            e;
  int            run_s;
  bit            run_act;
  int            reads;
  logic [DW-1:0] held_dat [LANES];
  logic [AW-1:0] held_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    run_act   = 1'b0;
    held_addr = '0;
    for (int i = 0; i < int'(LANES); i++) held_dat[i] = '0;
  endtask

  // Compare every output against what the model says for the current cycle
  task automatic check_now();
    int                  t;
    int                  k;
    logic [LANES-1:0]    ev;
    logic [LANES*DW-1:0] ed;
    t  = e - run_s;
    ev = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      k     = t - 3 - i * SK;
      ev[i] = run_act && (k >= 0) && (k < int'(DEPTH));
      ed[i*DW +: DW] = held_dat[i];
    end
    chk("busy",     64'(busy),     64'(run_act && t <= LAT));
    chk("pe_en",    64'(pe_en),    64'(run_act && t <= LAT));
    chk("done",     64'(done),     64'(run_act && t == LAT));
    chk("rd_en",    64'(rd_en),    64'(run_act && t >= 1 && t <= int'(DEPTH)));
    chk("rd_addr",  64'(rd_addr),  64'(held_addr));
    chk("out_vld",  64'(out_vld),  64'(ev));
    chk("out_data", 64'(out_data), 64'(ed));
  endtask

  // Advance one clock edge, update the model, then check
  task automatic step();
    logic st;
    int   t;
    int   k;
    st = start;
    @(posedge clk);
    #1;
    e++;
    if (rd_en) reads++;
    if (rst) begin
      model_reset();
    end else begin
      if (st && (!run_act || e >= run_s + LAT + 1)) begin
        run_act = 1'b1;
        run_s   = e;
      end
      if (run_act) begin
        t = e - run_s;
        if (t >= 1 && t <= int'(DEPTH)) held_addr = AW'(t - 1);
        for (int i = 0; i < int'(LANES); i++) begin
          k = t - 3 - i * SK;
          if (k >= 0 && k < int'(DEPTH)) held_dat[i] = mem[k][i*DW +: DW];
        end
      end
    end
    check_now();
  endtask

  task automatic load_pattern();
    for (int a = 0; a < int'(DEPTH); a++)
      for (int l = 0; l < int'(LANES); l++)
        mem[a][l*DW +: DW] = DW'(8'h10 * (l + 1) + a);
  endtask

  task automatic load_random();
    for (int a = 0; a < int'(DEPTH); a++)
      for (int l = 0; l < int'(LANES); l++)
        mem[a][l*DW +: DW] = DW'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    vectors     = 0;
    miscompares = 0;
    e           = 0;
    run_s       = 0;
    reads       = 0;
    model_reset();
    load_pattern();

    // Reset values, then a quiet idle period
    repeat (2) @(posedge clk);
    #1;
    check_now();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) step();
    chk("idle_reads", 64'(reads), 64'(0));

    // Directed run with the ramp pattern
    reads = 0;
    pulse_start();
    repeat (LAT + 2) step();
    chk("run_reads", 64'(reads), 64'(DEPTH));

    // Second start during the run must be ignored
    reads = 0;
    pulse_start();
    repeat (4) step();
    pulse_start();
    repeat (LAT - 5 + 2) step();
    chk("ignore_reads", 64'(reads), 64'(DEPTH));

    // Reset in the middle of a run, then a fresh full run
    load_random();
    pulse_start();
    repeat (7) step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_now();
    step();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) step();
    reads = 0;
    pulse_start();
    repeat (LAT + 2) step();
    chk("rerun_reads", 64'(reads), 64'(DEPTH));

    // Back-to-back runs: second start on the earliest accepted edge
    load_pattern();
    reads = 0;
    pulse_start();
    repeat (LAT) step();
    pulse_start();
    repeat (LAT + 2) step();
    chk("b2b_reads", 64'(reads), 64'(2 * DEPTH));

    // Random start traffic with random operands
    load_random();
    for (int c = 0; c < 120; c++) begin
      start = ($urandom_range(0, 3) == 0);
      step();
    end
    start = 1'b0;
    repeat (LAT + 2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
